// File: rtl/sha256_stream_arbiter.sv
// ---------------------------------------------------------------------------
// sha256_stream_arbiter
//
// Shares one byte-stream SHA-256 front-end between NREQ requesters. A grant
// lasts a whole message: the winner owns the core from its first input byte
// until the last of the 32 digest bytes has been handed back to it.
//
// Build option:
//   SHA_ARB_FIXED_PRIO_EN  defined   -> lowest-index valid requester wins
//                          undefined -> round-robin starting at rr_ptr
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   req_valid/data/last   per-requester byte stream, requester i on data[8i+:8]
//   req_ready             per-requester accept, only the owner in FEED
//   rsp_data/valid/last   digest byte, one-hot owner flag, 32nd-byte marker
//   core_din/valid/last   byte stream towards the front-end
//   core_ready            front-end input ready
//   core_dout/dvalid      digest bytes from the front-end
//   grant_vld, grant_id   current ownership (grant_id holds after release)
//   err_spur              pulse: digest byte arrived while not draining
// ---------------------------------------------------------------------------
module sha256_stream_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        rsp_data,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_last,
  output logic [7:0]        core_din,
  output logic              core_valid,
  output logic              core_last,
  input  logic              core_ready,
  input  logic [7:0]        core_dout,
  input  logic              core_dvalid,
  output logic              grant_vld,
  output logic [IDW-1:0]    grant_id,
  output logic              err_spur
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  win_id;
  logic [4:0]      byte_cnt;
  logic            own_valid;
  logic [7:0]      own_data;
  logic            own_last;
  logic            accept;
  logic            digest_done;

  logic [7:0]      rsp_data_p1;
  logic [NREQ-1:0] rsp_vld_p1;
  logic            rsp_last_p1;
  logic            err_spur_p1;

`ifndef SHA_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  scan;
  logic            found;
`endif

  // Owner's stream selected by the registered grant.
  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    own_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        own_valid = req_valid[i];
        own_data  = req_data[8*i +: 8];
        own_last  = req_last[i];
      end
    end
  end

  assign accept      = (state == FEED) && own_valid && core_ready;
  assign digest_done = (state == DRAIN) && core_dvalid && (byte_cnt == 5'd31);

  // Winner selection for the IDLE scan.
  always_comb begin
    win_id = '0;
`ifdef SHA_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) win_id = IDW'(i);
    end
`else
    scan  = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[scan]) begin
        win_id = scan;
        found  = 1'b1;
      end
      scan = (scan == IDW'(NREQ - 1)) ? '0 : scan + 1'b1;
    end
`endif
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid)          state_nxt = FEED;
      FEED:    if (accept && own_last)  state_nxt = DRAIN;
      DRAIN:   if (digest_done)         state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // FSM: outputs (combinational pass-through for the owner only)
  always_comb begin
    core_valid = 1'b0;
    core_din   = '0;
    core_last  = 1'b0;
    req_ready  = '0;
    if (state == FEED) begin
      core_valid          = own_valid;
      core_din            = own_data;
      core_last           = own_last;
      req_ready[grant_id] = core_ready;
    end
  end

  assign grant_vld = (state != IDLE);

  // Grant bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id <= '0;
      byte_cnt <= '0;
`ifndef SHA_ARB_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      if (state == IDLE && |req_valid) grant_id <= win_id;
      if (accept && own_last)          byte_cnt <= '0;
      else if (state == DRAIN && core_dvalid) byte_cnt <= byte_cnt + 5'd1;
`ifndef SHA_ARB_FIXED_PRIO_EN
      if (digest_done) rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
`endif
    end
  end

  // Stage p1: digest byte registered towards the owner, spurious-byte flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_p1 <= '0;
      rsp_vld_p1  <= '0;
      rsp_last_p1 <= 1'b0;
      err_spur_p1 <= 1'b0;
    end else begin
      rsp_vld_p1  <= '0;
      rsp_last_p1 <= 1'b0;
      err_spur_p1 <= core_dvalid && (state != DRAIN);
      if (state == DRAIN && core_dvalid) begin
        rsp_data_p1 <= core_dout;
        rsp_vld_p1  <= NREQ'(1) << grant_id;
        rsp_last_p1 <= (byte_cnt == 5'd31);
      end
    end
  end

  assign rsp_data  = rsp_data_p1;
  assign rsp_valid = rsp_vld_p1;
  assign rsp_last  = rsp_last_p1;
  assign err_spur  = err_spur_p1;

endmodule

// File: tb/tb_sha256_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sha256_stream_arbiter
//
// Directed bench for sha256_stream_arbiter (NREQ=2). A small front-end stub
// records accepted bytes and answers every completed message with the
// SHA-256 digest of "abc". Inputs are driven 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sha256_stream_arbiter;
  localparam int NREQ = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_valid;
  logic        rsp_last;
  logic [7:0]  core_din;
  logic        core_valid;
  logic        core_last;
  logic        core_ready;
  logic [7:0]  core_dout;
  logic        core_dvalid;
  logic        grant_vld;
  logic [0:0]  grant_id;
  logic        err_spur;

  logic        inj;
  logic        resp_dvalid = 1'b0;
  logic [7:0]  resp_dout = 8'h00;

  assign core_dvalid = resp_dvalid | inj;
  assign core_dout   = inj ? 8'h55 : resp_dout;

  always #5 clk = ~clk;

  sha256_stream_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last),
    .core_din(core_din), .core_valid(core_valid), .core_last(core_last),
    .core_ready(core_ready), .core_dout(core_dout), .core_dvalid(core_dvalid),
    .grant_vld(grant_vld), .grant_id(grant_id), .err_spur(err_spur)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] dig [32];
  logic [7:0] msg_q [$];
  logic [7:0] rx_q [$];
  logic [7:0] rsp_d_q [$];
  logic [1:0] rsp_v_q [$];
  logic       rsp_l_q [$];
  logic [0:0] grant_q [$];
  int         last_seen = 0;
  int         last_served = 0;
  int         leak = 0;
  logic       gv_prev = 1'b0;
  bit         active = 1'b0;
  int         didx = 0;

  // Monitor: accepted core bytes, response beats, new grants, foreign readies
  always @(negedge clk) begin
    if (!rst) begin
      if (core_valid && core_ready) begin
        rx_q.push_back(core_din);
        if (core_last) last_seen++;
      end
      if (rsp_valid != 2'b00) begin
        rsp_d_q.push_back(rsp_data);
        rsp_v_q.push_back(rsp_valid);
        rsp_l_q.push_back(rsp_last);
      end
      if (grant_vld && !gv_prev) grant_q.push_back(grant_id);
      if ((req_ready & ~(2'b01 << grant_id)) != 2'b00) leak++;
    end
    gv_prev = grant_vld;
  end

  // Front-end stub: one idle cycle after the last byte, then 32 digest bytes
  always @(posedge clk) begin
    #2;
    resp_dvalid = 1'b0;
    if (rst) begin
      active      = 1'b0;
      last_served = last_seen;
    end else if (active) begin
      resp_dvalid = 1'b1;
      resp_dout   = dig[didx];
      didx++;
      if (didx == 32) active = 1'b0;
    end else if (last_served != last_seen) begin
      last_served++;
      active = 1'b1;
      didx   = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; inj = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] gq(input int i);
    return (i < grant_q.size()) ? 32'(grant_q[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] rq(input int i);
    return (i < rsp_d_q.size()) ? 32'(rsp_d_q[i]) : 32'hDEAD;
  endfunction

  task automatic send_msg(input int r, input string nm);
    for (int k = 0; k < msg_q.size(); k++) begin
      int   t;
      logic acc;
      req_valid[r]        = 1'b1;
      req_data[8*r +: 8]  = msg_q[k];
      req_last[r]         = (k == msg_q.size() - 1);
      t   = 0;
      acc = 1'b0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = req_ready[r];
        step();
        t++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL %s_beat%0d: not accepted after %0d cycles, required within 200", nm, k, t);
        break;
      end
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((grant_vld || active) && t < 300);
    chk({nm, "_idle_reached"}, 32'(t < 300), 32'd1);
    step();
    step();
  endtask

  task automatic chk_rx(input string nm, input int base);
    int bad = 0;
    chk({nm, "_rx_count"}, 32'(rx_q.size() - base), 32'(msg_q.size()));
    for (int k = 0; k < msg_q.size(); k++)
      if (base + k >= rx_q.size() || rx_q[base + k] !== msg_q[k]) bad++;
    chk({nm, "_rx_bytes_bad"}, 32'(bad), 32'd0);
  endtask

  task automatic chk_digest(input string nm, input int base, input logic [1:0] vexp);
    int bad = 0;
    int lbad = 0;
    chk({nm, "_rsp_count"}, 32'(rsp_d_q.size() - base), 32'd32);
    chk({nm, "_rsp_first"}, rq(base), 32'hBA);
    chk({nm, "_rsp_last_byte"}, rq(base + 31), 32'hAD);
    for (int k = 0; k < 32; k++) begin
      if (base + k < rsp_d_q.size()) begin
        if (rsp_d_q[base + k] !== dig[k] || rsp_v_q[base + k] !== vexp) bad++;
        if (rsp_l_q[base + k] !== (k == 31)) lbad++;
      end
    end
    chk({nm, "_rsp_bytes_bad"}, 32'(bad), 32'd0);
    chk({nm, "_rsp_last_flag_bad"}, 32'(lbad), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  rv;
    logic [15:0] rd;
    logic [1:0]  rl;
    logic        cr;
    logic        cv;
    logic [7:0]  cd;
    logic        cl;
    logic [1:0]  rr;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] dv;
    vec_t         tbl [7];
    logic [31:0]  g_exp [4];
    int           rb, pb, gb, t;

    // Owner 0 in FEED: {req_valid, req_data, req_last, core_ready} -> {core_valid, core_din, core_last, req_ready}
    tbl[0] = '{2'b01, 16'hEE11, 2'b00, 1'b1, 1'b1, 8'h11, 1'b0, 2'b01};
    tbl[1] = '{2'b11, 16'hEE22, 2'b00, 1'b1, 1'b1, 8'h22, 1'b0, 2'b01};
    tbl[2] = '{2'b11, 16'hEE33, 2'b01, 1'b0, 1'b1, 8'h33, 1'b1, 2'b00};
    tbl[3] = '{2'b10, 16'hEE44, 2'b10, 1'b1, 1'b0, 8'h44, 1'b0, 2'b01};
    tbl[4] = '{2'b00, 16'h0000, 2'b11, 1'b0, 1'b0, 8'h00, 1'b1, 2'b00};
    tbl[5] = '{2'b01, 16'h5AA5, 2'b10, 1'b1, 1'b1, 8'hA5, 1'b0, 2'b01};
    tbl[6] = '{2'b11, 16'hFF00, 2'b01, 1'b0, 1'b1, 8'h00, 1'b1, 2'b00};

    dv = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    for (int k = 0; k < 32; k++) dig[k] = dv[255 - 8*k -: 8];

    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; core_ready = 1'b0; inj = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_grant_vld", 32'(grant_vld), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_core_valid", 32'(core_valid), 32'd0);
    chk("rst_core_last", 32'(core_last), 32'd0);
    chk("rst_core_din", 32'(core_din), 32'd0);
    chk("rst_err_spur", 32'(err_spur), 32'd0);
    step();
    rst = 1'b0;

    // T1: "abc" from requester 0
    core_ready = 1'b1;
    msg_q = '{8'h61, 8'h62, 8'h63};
    rb = rx_q.size(); pb = rsp_d_q.size(); gb = grant_q.size();
    send_msg(0, "t1");
    wait_idle("t1");
    chk_rx("t1", rb);
    chk_digest("t1", pb, 2'b01);
    chk("t1_grant", gq(gb), 32'd0);

    // T2: both requesters persistently valid with 1-byte messages
    do_reset();
    rb = rx_q.size(); gb = grant_q.size();
    req_data = 16'hB1A0; req_last = 2'b11; req_valid = 2'b11;
    t = 0;
    while (grant_q.size() - gb < 4 && t < 1000) begin
      step();
      t++;
    end
    req_valid = '0; req_last = '0;
    wait_idle("t2");
`ifdef SHA_ARB_FIXED_PRIO_EN
    g_exp = '{32'd0, 32'd0, 32'd0, 32'd0};
    msg_q = '{8'hA0, 8'hA0, 8'hA0, 8'hA0};
`else
    g_exp = '{32'd0, 32'd1, 32'd0, 32'd1};
    msg_q = '{8'hA0, 8'hB1, 8'hA0, 8'hB1};
`endif
    chk("t2_grant_count", 32'(grant_q.size() - gb), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("t2_grant%0d", k), gq(gb + k), g_exp[k]);
    chk_rx("t2", rb);

    // T3: core_ready low for 5 cycles in the middle of an 8-byte message
    msg_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    rb = rx_q.size(); pb = rsp_d_q.size();
    fork
      send_msg(0, "t3");
      begin
        step(); step(); step();
        core_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("t3_stall_ready%0d", k), 32'(req_ready), 32'd0);
          step();
        end
        core_ready = 1'b1;
      end
    join
    wait_idle("t3");
    chk_rx("t3", rb);
    chk_digest("t3", pb, 2'b01);

    // T4: 1-byte message from requester 0 while requester 1 waits
    do_reset();
    core_ready = 1'b1;
    rb = rx_q.size(); pb = rsp_d_q.size(); gb = grant_q.size();
    req_data = 16'hEE42; req_last = 2'b11; req_valid = 2'b11;
    @(negedge clk);
    chk("t4_idle_req_ready", 32'(req_ready), 32'd0);
    chk("t4_idle_core_valid", 32'(core_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t4_feed_grant_id", 32'(grant_id), 32'd0);
    chk("t4_feed_core_din", 32'(core_din), 32'h42);
    chk("t4_feed_req_ready", 32'(req_ready), 32'b01);
    step();
    req_valid = 2'b10; req_last = 2'b10;
    @(negedge clk);
    chk("t4_drain_grant_vld", 32'(grant_vld), 32'd1);
    chk("t4_drain_core_valid", 32'(core_valid), 32'd0);
    chk("t4_drain_req_ready", 32'(req_ready), 32'd0);
    t = 0;
    while (grant_q.size() - gb < 2 && t < 200) begin
      step();
      t++;
    end
    req_valid = '0; req_last = '0;
    chk_digest("t4a", pb, 2'b01);
    chk("t4_second_grant", gq(gb + 1), 32'd1);
    wait_idle("t4");
    chk_digest("t4b", pb + 32, 2'b10);
    msg_q = '{8'h42, 8'hEE};
    chk_rx("t4", rb);

    // Table: combinational pass-through while requester 0 owns the core
    core_ready = 1'b0; req_data = '0; req_last = '0; req_valid = 2'b01;
    rb = rx_q.size(); pb = rsp_d_q.size();
    step();
    @(negedge clk);
    chk("tbl_grant_vld", 32'(grant_vld), 32'd1);
    chk("tbl_grant_id", 32'(grant_id), 32'd0);
    step();
    for (int i = 0; i < 7; i++) begin
      req_valid = tbl[i].rv; req_data = tbl[i].rd; req_last = tbl[i].rl; core_ready = tbl[i].cr;
      @(negedge clk);
      chk($sformatf("tbl%0d_core_valid", i), 32'(core_valid), 32'(tbl[i].cv));
      chk($sformatf("tbl%0d_core_din", i), 32'(core_din), 32'(tbl[i].cd));
      chk($sformatf("tbl%0d_core_last", i), 32'(core_last), 32'(tbl[i].cl));
      chk($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].rr));
      step();
    end
    req_valid = 2'b01; req_data = 16'h0077; req_last = 2'b01; core_ready = 1'b1;
    step();
    req_valid = '0; req_last = '0;
    wait_idle("tbl");
    msg_q = '{8'h11, 8'h22, 8'hA5, 8'h77};
    chk_rx("tbl", rb);
    chk_digest("tbl", pb, 2'b01);

    // T5: reset while draining, then round-robin pointer and spurious digest byte
    do_reset();
    msg_q = '{8'h5C};
    send_msg(0, "t5a");
    wait_idle("t5a");
    msg_q = '{8'hC5};
    pb = rsp_d_q.size();
    send_msg(1, "t5b");
    t = 0;
    while (rsp_d_q.size() - pb < 10 && t < 200) begin
      @(negedge clk);
      t++;
    end
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("t5_rst_grant_vld", 32'(grant_vld), 32'd0);
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_rsp_last", 32'(rsp_last), 32'd0);
    step();
    rst = 1'b0;
    req_data = 16'hB1A0; req_last = 2'b11; req_valid = 2'b11;
    step();
    @(negedge clk);
    chk("t5_rr_grant_vld", 32'(grant_vld), 32'd1);
    chk("t5_rr_grant_id", 32'(grant_id), 32'd0);
    step();
    req_valid = '0; req_last = '0;
    wait_idle("t5");
    inj = 1'b1;
    @(negedge clk);
    chk("t5_spur_before", 32'(err_spur), 32'd0);
    step();
    inj = 1'b0;
    @(negedge clk);
    chk("t5_spur_pulse", 32'(err_spur), 32'd1);
    chk("t5_spur_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t5_spur_after", 32'(err_spur), 32'd0);
    chk("t5_spur_grant_vld", 32'(grant_vld), 32'd0);

    chk("no_foreign_ready", 32'(leak), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
